// File: rtl/inv_share_monitor.sv
`default_nettype none
// ============================================================================
// Module   : inv_share_monitor
// Purpose  : Response checker for a masked GF(2^8) inversion core with two
//            input shares and four output shares. It recombines the input
//            shares, delays the unmasked value by the core latency, recombines
//            the output shares and compares them with an unmasked golden
//            inverse. It keeps run statistics over N_VECTORS checked vectors.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   1   clock, rising edge
//   RST          in   1   asynchronous active-high reset
//   start        in   1   one-cycle pulse, starts a run from IDLE or DONE
//   in_valid     in   1   in0/in1 carry a new vector
//   in0, in1     in   8   input shares (as driven to the core)
//   out0..out3   in   8   output shares of the core
//   busy         out  1   run in progress
//   done         out  1   run complete, held until next start or reset
//   pass         out  1   done with zero mismatches
//   err_cnt      out  16  mismatch count, saturating
//   chk_cnt      out  17  vectors checked in the current run
//   first_err_x  out  8   unmasked input of the first mismatch
//   first_err_q  out  8   recombined output of the first mismatch
// ============================================================================
module inv_share_monitor #(
  parameter int LATENCY   = 2,
  parameter int N_VECTORS = 65536
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  out0,
  input  logic [7:0]  out1,
  input  logic [7:0]  out2,
  input  logic [7:0]  out3,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [16:0] chk_cnt,
  output logic [7:0]  first_err_x,
  output logic [7:0]  first_err_q
);

  localparam logic [16:0] C_N_VEC   = 17'(N_VECTORS);
  localparam logic [15:0] C_ERR_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  state_t                    state_q, state_d;
  logic [LATENCY-1:0]        dv_q, dv_d;
  logic [LATENCY-1:0][7:0]   dx_q, dx_d;
  logic [15:0]               err_q, err_d;
  logic [16:0]               chk_q, chk_d;
  logic [7:0]                fex_q, fex_d;
  logic [7:0]                feq_q, feq_d;
  logic                      busy_q, done_q, pass_q;

  logic [7:0] w_x;
  logic [7:0] w_q;
  logic [7:0] w_gold;
  logic       w_check;
  logic       w_mismatch;
  logic       w_last;

  assign w_x        = in0 ^ in1;
  assign w_q        = out0 ^ out1 ^ out2 ^ out3;
  assign w_gold     = gf_inv(dx_q[LATENCY-1]);
  assign w_check    = dv_q[LATENCY-1] && (state_q == ST_RUN);
  assign w_mismatch = (w_gold != w_q);
  assign w_last     = ((chk_q + 17'd1) == C_N_VEC);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    chk_d   = chk_q;
    fex_d   = fex_q;
    feq_d   = feq_q;

    // Delay line shifts every cycle; only vectors offered while running enter.
    dv_d    = dv_q;
    dx_d    = dx_q;
    dv_d[0] = in_valid && (state_q == ST_RUN);
    dx_d[0] = w_x;
    for (int i = 1; i < LATENCY; i++) begin
      dv_d[i] = dv_q[i-1];
      dx_d[i] = dx_q[i-1];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          err_d   = 16'd0;
          chk_d   = 17'd0;
          fex_d   = 8'd0;
          feq_d   = 8'd0;
          // Results still in flight from before the run must not be checked.
          dv_d    = '0;
        end
      end
      ST_RUN: begin
        if (w_check) begin
          chk_d = chk_q + 17'd1;
          if (w_mismatch) begin
            if (err_q != C_ERR_MAX) err_d = err_q + 16'd1;
            if (err_q == 16'd0) begin
              fex_d = dx_q[LATENCY-1];
              feq_d = w_q;
            end
          end
          if (w_last) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      dv_q    <= '0;
      dx_q    <= '0;
      err_q   <= 16'd0;
      chk_q   <= 17'd0;
      fex_q   <= 8'd0;
      feq_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q    <= dv_d;
      dx_q    <= dx_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      fex_q   <= fex_d;
      feq_q   <= feq_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
      pass_q  <= (state_d == ST_DONE) && (err_d == 16'd0);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_q;
  assign chk_cnt     = chk_q;
  assign first_err_x = fex_q;
  assign first_err_q = feq_q;

endmodule
`default_nettype wire
